// File: rtl/video_source_switch.sv
// video_source_switch: N-input video selector. Source changes happen only on frame
// edges, with muted output between the old and new source and optional holdoff frames.
module video_source_switch #(
    parameter int unsigned NUM_SRC        = 4,
    parameter int unsigned SEL_W          = 2,
    parameter int unsigned COLOR_W        = 12,
    parameter bit          SYNC_POL       = 1'b1,
    parameter int unsigned DEFAULT_SRC    = 0,
    parameter int unsigned HOLDOFF_FRAMES = 1,
    parameter int unsigned VS_TIMEOUT     = 4194304
) (
    input  logic                       sys_clk,
    input  logic                       reset_n,
    input  logic [NUM_SRC-1:0]         src_de,
    input  logic [NUM_SRC-1:0]         src_hs,
    input  logic [NUM_SRC-1:0]         src_vs,
    input  logic [NUM_SRC*COLOR_W-1:0] src_r,
    input  logic [NUM_SRC*COLOR_W-1:0] src_g,
    input  logic [NUM_SRC*COLOR_W-1:0] src_b,
    input  logic [SEL_W-1:0]           sel_req,
    input  logic                       sel_req_valid,
    output logic [SEL_W-1:0]           sel_active,
    output logic                       switch_busy,
    output logic                       sel_err,
    output logic                       vs_timeout,
    output logic                       out_de,
    output logic                       out_hs,
    output logic                       out_vs,
    output logic [COLOR_W-1:0]         out_r,
    output logic [COLOR_W-1:0]         out_g,
    output logic [COLOR_W-1:0]         out_b
);

    // Slots padded to a power of two so any SEL_W-bit select indexes a real entry.
    localparam int unsigned       NSLOT     = 1 << SEL_W;
    localparam int unsigned       TO_W      = $clog2(VS_TIMEOUT + 1);
    localparam logic [SEL_W-1:0]  DEF_SEL   = SEL_W'(DEFAULT_SRC);
    localparam logic [SEL_W:0]    NUM_SRC_X = (SEL_W + 1)'(NUM_SRC);
    localparam logic [3:0]        HOLD_INIT = 4'(HOLDOFF_FRAMES);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(VS_TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StWaitCurVs, StWaitNewVs, StHoldoff} state_e;

    state_e               state;
    logic [SEL_W-1:0]     target;
    logic                 pend_valid;
    logic [SEL_W-1:0]     pend_sel;
    logic [3:0]           hold_cnt;
    logic [TO_W-1:0]      to_cnt;

    logic [NSLOT-1:0]     de_slot, hs_slot, vs_slot, vs_act, vs_act_prev, edge_slot;
    logic [COLOR_W-1:0]   r_slot [NSLOT];
    logic [COLOR_W-1:0]   g_slot [NSLOT];
    logic [COLOR_W-1:0]   b_slot [NSLOT];

    logic                 cur_de, cur_hs, cur_vs, cur_edge;
    logic [COLOR_W-1:0]   cur_r, cur_g, cur_b;
    logic                 req_in_range, req_ok, to_hit;
    logic                 idle_req;
    logic [SEL_W-1:0]     idle_sel;

    // Unpack the flat source buses into per-slot signals; unused slots read as zero.
    always_comb begin
        de_slot = '0;
        hs_slot = '0;
        vs_slot = '0;
        for (int k = 0; k < NSLOT; k++) begin
            r_slot[k] = '0;
            g_slot[k] = '0;
            b_slot[k] = '0;
        end
        for (int k = 0; k < NUM_SRC; k++) begin
            de_slot[k] = src_de[k];
            hs_slot[k] = src_hs[k];
            vs_slot[k] = src_vs[k];
            r_slot[k]  = src_r[k*COLOR_W +: COLOR_W];
            g_slot[k]  = src_g[k*COLOR_W +: COLOR_W];
            b_slot[k]  = src_b[k*COLOR_W +: COLOR_W];
        end
    end

    // Edges are tracked on every source so the monitored one can change without a false edge.
    assign vs_act    = vs_slot ^ {NSLOT{~SYNC_POL}};
    assign edge_slot = vs_act & ~vs_act_prev;

    assign cur_de   = de_slot[sel_active];
    assign cur_hs   = hs_slot[sel_active];
    assign cur_vs   = vs_slot[sel_active];
    assign cur_r    = r_slot[sel_active];
    assign cur_g    = g_slot[sel_active];
    assign cur_b    = b_slot[sel_active];
    assign cur_edge = edge_slot[sel_active];

    assign req_in_range = ({1'b0, sel_req} < NUM_SRC_X);
    assign req_ok       = sel_req_valid && req_in_range;
    assign to_hit       = (to_cnt == TO_LAST);

    // In IDLE a fresh strobe overrides any request left pending from the last switch.
    assign idle_req = req_ok || pend_valid;
    assign idle_sel = req_ok ? sel_req : pend_sel;

    // Registered copy of every source's active-level vsync for edge detection.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_act_prev <= '0;
        end else begin
            vs_act_prev <= vs_act;
        end
    end

    // Switch FSM with registered status and video outputs.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= StIdle;
            sel_active  <= DEF_SEL;
            target      <= DEF_SEL;
            pend_valid  <= 1'b0;
            pend_sel    <= '0;
            hold_cnt    <= '0;
            to_cnt      <= '0;
            switch_busy <= 1'b0;
            sel_err     <= 1'b0;
            vs_timeout  <= 1'b0;
            out_de      <= 1'b0;
            out_hs      <= ~SYNC_POL;
            out_vs      <= ~SYNC_POL;
            out_r       <= '0;
            out_g       <= '0;
            out_b       <= '0;
        end else begin
            sel_err    <= sel_req_valid && !req_in_range;
            vs_timeout <= 1'b0;
            out_de     <= cur_de;
            out_hs     <= cur_hs;
            out_vs     <= cur_vs;
            out_r      <= cur_r;
            out_g      <= cur_g;
            out_b      <= cur_b;

            if (state != StIdle && req_ok) begin
                pend_valid <= 1'b1;
                pend_sel   <= sel_req;
            end

            unique case (state)
                StIdle: begin
                    to_cnt     <= '0;
                    pend_valid <= 1'b0;
                    if (idle_req && idle_sel != sel_active) begin
                        target      <= idle_sel;
                        switch_busy <= 1'b1;
                        state       <= StWaitCurVs;
                    end
                end
                StWaitCurVs: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (cur_edge || to_hit) begin
                        sel_active <= target;
                        to_cnt     <= '0;
                        state      <= StWaitNewVs;
                        vs_timeout <= !cur_edge;
                        out_de     <= 1'b0;
                        out_hs     <= ~SYNC_POL;
                        out_vs     <= ~SYNC_POL;
                        out_r      <= '0;
                        out_g      <= '0;
                        out_b      <= '0;
                    end
                end
                StWaitNewVs: begin
                    to_cnt <= to_cnt + 1'b1;
                    out_de <= 1'b0;
                    out_hs <= ~SYNC_POL;
                    out_vs <= ~SYNC_POL;
                    out_r  <= '0;
                    out_g  <= '0;
                    out_b  <= '0;
                    if (cur_edge) begin
                        // New source's syncs start with its own frame edge.
                        out_hs <= cur_hs;
                        out_vs <= cur_vs;
                        to_cnt <= '0;
                        if (HOLDOFF_FRAMES == 0) begin
                            switch_busy <= 1'b0;
                            state       <= StIdle;
                        end else begin
                            hold_cnt <= HOLD_INIT;
                            state    <= StHoldoff;
                        end
                    end else if (to_hit) begin
                        to_cnt      <= '0;
                        vs_timeout  <= 1'b1;
                        switch_busy <= 1'b0;
                        state       <= StIdle;
                    end
                end
                StHoldoff: begin
                    out_de <= 1'b0;
                    out_r  <= '0;
                    out_g  <= '0;
                    out_b  <= '0;
                    if (cur_edge) begin
                        hold_cnt <= hold_cnt - 1'b1;
                        if (hold_cnt == 4'd1) begin
                            switch_busy <= 1'b0;
                            state       <= StIdle;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_video_source_switch.sv
// tb_video_source_switch: directed bench for video_source_switch with four synthetic
// sources (100-cycle frames, 30-cycle phase offset between sources).
module tb_video_source_switch;

    localparam int   NS = 4;
    localparam int   CW = 12;
    localparam int   SW = 3;   // widened so out-of-range index 5 is representable
    localparam logic SP = 1'b1;
    localparam int   MODE_PASS = 0;
    localparam int   MODE_MUTE = 1;
    localparam int   MODE_SYNC = 2;

    logic              sys_clk = 1'b0;
    logic              reset_n;
    logic [NS-1:0]     src_de, src_hs, src_vs;
    logic [NS*CW-1:0]  src_r, src_g, src_b;
    logic [SW-1:0]     sel_req;
    logic              sel_req_valid;
    logic [SW-1:0]     sel_active;
    logic              switch_busy, sel_err, vs_timeout;
    logic              out_de, out_hs, out_vs;
    logic [CW-1:0]     out_r, out_g, out_b;

    int        cyc;
    int        n_checks;
    int        n_pass;
    bit [3:0]  kill;
    bit        watch3;
    bit        saw3;

    video_source_switch #(
        .NUM_SRC        (NS),
        .SEL_W          (SW),
        .COLOR_W        (CW),
        .SYNC_POL       (SP),
        .DEFAULT_SRC    (0),
        .HOLDOFF_FRAMES (1),
        .VS_TIMEOUT     (1000)
    ) dut (
        .sys_clk       (sys_clk),
        .reset_n       (reset_n),
        .src_de        (src_de),
        .src_hs        (src_hs),
        .src_vs        (src_vs),
        .src_r         (src_r),
        .src_g         (src_g),
        .src_b         (src_b),
        .sel_req       (sel_req),
        .sel_req_valid (sel_req_valid),
        .sel_active    (sel_active),
        .switch_busy   (switch_busy),
        .sel_err       (sel_err),
        .vs_timeout    (vs_timeout),
        .out_de        (out_de),
        .out_hs        (out_hs),
        .out_vs        (out_vs),
        .out_r         (out_r),
        .out_g         (out_g),
        .out_b         (out_b)
    );

    always #5 sys_clk = ~sys_clk;

    // {de, hs, vs, r, g, b} of source k at cycle c.
    function automatic logic [38:0] src_word(int k, int c);
        int         p;
        logic       de, hs, vs;
        logic [11:0] r, g, b;
        p  = (c + k * 30) % 100;
        vs = (p < 3) && !kill[k];
        hs = (p % 20) < 2;
        de = (p >= 10) && (p < 90);
        r  = 12'(k * 256 + p);
        g  = 12'(3840 - p * 3 - k);
        b  = 12'(p * 7 + k * 512);
        return {de, hs, vs, r, g, b};
    endfunction

    function automatic logic [38:0] out_word();
        return {out_de, out_hs, out_vs, out_r, out_g, out_b};
    endfunction

    function automatic logic [38:0] expect_word(int mode, int k);
        logic [38:0] w;
        w = src_word(k, cyc - 1);
        if (mode == MODE_PASS) return w;
        if (mode == MODE_MUTE) return {1'b0, ~SP, ~SP, 36'd0};
        return {1'b0, w[37], w[36], 36'd0};
    endfunction

    task automatic check(input string tag, input logic [38:0] got, input logic [38:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at cyc %0d: got %h, expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic drive_src();
        logic [38:0] w;
        for (int k = 0; k < NS; k++) begin
            w = src_word(k, cyc);
            src_de[k]          = w[38];
            src_hs[k]          = w[37];
            src_vs[k]          = w[36];
            src_r[k*CW +: CW]  = w[35:24];
            src_g[k*CW +: CW]  = w[23:12];
            src_b[k*CW +: CW]  = w[11:0];
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
        sel_req_valid = 1'b0;
        cyc = cyc + 1;
        drive_src();
        if (watch3 && sel_active == 3'd3) saw3 = 1'b1;
    endtask

    task automatic run_until(input int last, input int mode, input int k, input string tag);
        while (cyc < last) begin
            step();
            check(tag, out_word(), expect_word(mode, k));
        end
    endtask

    task automatic request(input logic [SW-1:0] s);
        sel_req       = s;
        sel_req_valid = 1'b1;
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        cyc           = 0;
        kill          = '0;
        watch3        = 1'b0;
        saw3          = 1'b0;
        reset_n       = 1'b0;
        sel_req       = '0;
        sel_req_valid = 1'b0;
        drive_src();

        // Reset values while source 0 vsync is active.
        step();
        step();
        check("rst_out", out_word(), {1'b0, ~SP, ~SP, 36'd0});
        check("rst_sel", 39'(sel_active), 39'd0);
        check("rst_busy", 39'(switch_busy), 39'd0);
        check("rst_err", 39'(sel_err), 39'd0);
        check("rst_to", 39'(vs_timeout), 39'd0);
        reset_n = 1'b1;
        run_until(150, MODE_PASS, 0, "pass_src0");

        // Switch 0 -> 2 mid-frame.
        request(3'd2);
        run_until(151, MODE_PASS, 0, "sw2_hold_cur");
        check("sw2_busy_on", 39'(switch_busy), 39'd1);
        run_until(200, MODE_PASS, 0, "sw2_hold_cur");
        check("sw2_sel_before", 39'(sel_active), 39'd0);
        run_until(201, MODE_MUTE, 0, "sw2_mute");
        check("sw2_sel_after", 39'(sel_active), 39'd2);
        run_until(240, MODE_MUTE, 0, "sw2_mute");
        run_until(340, MODE_SYNC, 2, "sw2_holdoff");
        check("sw2_busy_hold", 39'(switch_busy), 39'd1);
        run_until(341, MODE_SYNC, 2, "sw2_holdoff");
        check("sw2_busy_off", 39'(switch_busy), 39'd0);
        run_until(400, MODE_PASS, 2, "pass_src2");

        // Out-of-range request, then request of the current source.
        request(3'd5);
        run_until(401, MODE_PASS, 2, "err_pass");
        check("err_pulse", 39'(sel_err), 39'd1);
        check("err_busy", 39'(switch_busy), 39'd0);
        check("err_sel", 39'(sel_active), 39'd2);
        run_until(402, MODE_PASS, 2, "err_pass");
        check("err_single", 39'(sel_err), 39'd0);
        run_until(410, MODE_PASS, 2, "err_pass");
        request(3'd2);
        run_until(411, MODE_PASS, 2, "same_pass");
        check("same_busy", 39'(switch_busy), 39'd0);
        check("same_err", 39'(sel_err), 39'd0);
        run_until(500, MODE_PASS, 2, "same_pass");

        // Pending requests: 1, then 3 and 2 while busy; latest pending wins.
        watch3 = 1'b1;
        request(3'd1);
        run_until(510, MODE_PASS, 2, "pend_cur");
        request(3'd3);
        run_until(520, MODE_PASS, 2, "pend_cur");
        request(3'd2);
        run_until(540, MODE_PASS, 2, "pend_cur");
        run_until(541, MODE_MUTE, 0, "pend_mute1");
        check("pend_sel1", 39'(sel_active), 39'd1);
        run_until(570, MODE_MUTE, 0, "pend_mute1");
        run_until(671, MODE_SYNC, 1, "pend_hold1");
        check("pend_busy_dip", 39'(switch_busy), 39'd0);
        run_until(672, MODE_PASS, 1, "pend_pass1");
        check("pend_busy_again", 39'(switch_busy), 39'd1);
        run_until(770, MODE_PASS, 1, "pend_pass1");
        run_until(840, MODE_MUTE, 0, "pend_mute2");
        check("pend_sel2", 39'(sel_active), 39'd2);
        run_until(941, MODE_SYNC, 2, "pend_hold2");
        check("pend_done_busy", 39'(switch_busy), 39'd0);
        check("pend_done_sel", 39'(sel_active), 39'd2);
        run_until(1000, MODE_PASS, 2, "pend_pass2");
        watch3 = 1'b0;
        check("never_sel3", 39'(saw3), 39'd0);

        // Dead target source: timeout out of WAIT_NEW_VS.
        kill[3] = 1'b1;
        request(3'd3);
        run_until(1040, MODE_PASS, 2, "to_cur");
        run_until(1041, MODE_MUTE, 0, "to_mute");
        check("to_sel", 39'(sel_active), 39'd3);
        run_until(2040, MODE_MUTE, 0, "to_mute");
        check("to_not_yet", 39'(vs_timeout), 39'd0);
        check("to_busy_wait", 39'(switch_busy), 39'd1);
        run_until(2041, MODE_MUTE, 0, "to_mute");
        check("to_pulse", 39'(vs_timeout), 39'd1);
        check("to_busy_off", 39'(switch_busy), 39'd0);
        check("to_sel_final", 39'(sel_active), 39'd3);
        run_until(2042, MODE_PASS, 3, "to_pass3");
        check("to_single", 39'(vs_timeout), 39'd0);
        run_until(2050, MODE_PASS, 3, "to_pass3");
        kill[3] = 1'b0;

        // Reset in HOLDOFF with a request pending.
        run_until(2100, MODE_PASS, 3, "rh_pass3");
        request(3'd1);
        run_until(2110, MODE_PASS, 3, "rh_cur");
        run_until(2170, MODE_MUTE, 0, "rh_mute");
        run_until(2180, MODE_SYNC, 1, "rh_hold");
        request(3'd3);
        run_until(2200, MODE_SYNC, 1, "rh_hold");
        check("rh_busy_pre", 39'(switch_busy), 39'd1);
        check("rh_sel_pre", 39'(sel_active), 39'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rh_async_out", out_word(), {1'b0, ~SP, ~SP, 36'd0});
        check("rh_async_sel", 39'(sel_active), 39'd0);
        check("rh_async_busy", 39'(switch_busy), 39'd0);
        step();
        step();
        reset_n = 1'b1;
        run_until(cyc + 300, MODE_PASS, 0, "rh_after");
        check("rh_final_busy", 39'(switch_busy), 39'd0);
        check("rh_final_sel", 39'(sel_active), 39'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
